// File: rtl/adc_scan_avg.sv
// adc_scan_avg: round-robin channel scanner and per-channel
// averager driving an ADC128S052 serial capture stage.
module adc_scan_avg #(
  parameter int avg_log2 = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        scan_en,
  input  logic [7:0]  channel_mask,
  input  logic        adc_ready,
  input  logic [11:0] d_signal,
  output logic        adc_en,
  output logic        adc_ack,
  output logic [2:0]  address,
  output logic        result_valid,
  input  logic        result_ready,
  output logic [2:0]  result_ch,
  output logic [11:0] result_data,
  output logic        busy
);

  localparam int AW = 12 + avg_log2;
  localparam int CW = avg_log2 + 1;
  localparam logic [CW-1:0] LAST =
    CW'((1 << avg_log2) - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] ACK  = 2'd2;

  logic [1:0]    state;
  logic [AW-1:0] acc;
  logic [CW-1:0] cnt;
  logic [CW-1:0] issue_cnt;
  logic [2:0]    tag;
  logic          tag_valid;
  logic          stop_pend;

  logic          start;
  logic          stall;
  logic          capture;
  logic          go_idle;
  logic          last_issue;
  logic          done;
  logic [2:0]    first_ch;
  logic [2:0]    next_ch;
  logic [AW-1:0] sum;

  assign start      = scan_en && (|channel_mask);
  assign stall      = result_valid && !result_ready;
  assign capture    = (state == WAIT) && scan_en &&
                      adc_ready && !stall;
  assign go_idle    = ((state == WAIT) && !scan_en) ||
                      ((state == ACK) && !adc_ready &&
                       (!scan_en || stop_pend));
  assign last_issue = (issue_cnt == LAST);
  assign done       = (cnt == LAST);
  assign sum        = acc + AW'(d_signal);

  // lowest enabled channel, used when a scan starts
  always_comb begin
    first_ch = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (channel_mask[i]) first_ch = 3'(i);
  end

  // next enabled channel above the current one, wrapping
  always_comb begin
    next_ch = address;
    for (int i = 7; i >= 1; i--)
      if (channel_mask[3'(address + 3'(i))])
        next_ch = 3'(address + 3'(i));
  end

  // scan state, address schedule and sample channel tag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      address   <= 3'd0;
      issue_cnt <= '0;
      tag       <= 3'd0;
      tag_valid <= 1'b0;
      stop_pend <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= WAIT;
            address   <= first_ch;
            issue_cnt <= '0;
            tag_valid <= 1'b0;
            stop_pend <= 1'b0;
          end
        end
        WAIT: begin
          if (go_idle) begin
            state     <= IDLE;
            tag_valid <= 1'b0;
          end else if (capture) begin
            state     <= ACK;
            tag       <= address;
            tag_valid <= 1'b1;
            if (last_issue) begin
              issue_cnt <= '0;
              address   <= next_ch;
              stop_pend <= ~|channel_mask;
            end else begin
              issue_cnt <= issue_cnt + 1'b1;
            end
          end
        end
        ACK: begin
          if (go_idle) begin
            state     <= IDLE;
            tag_valid <= 1'b0;
          end else if (!adc_ready) begin
            state <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // running sum; a partial average is dropped on leaving the scan
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if ((state == IDLE) || go_idle) begin
      acc <= '0;
      cnt <= '0;
    end else if (capture && tag_valid) begin
      if (done) begin
        acc <= '0;
        cnt <= '0;
      end else begin
        acc <= sum;
        cnt <= cnt + 1'b1;
      end
    end
  end

  // averaged result register with valid/ready hold
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_valid <= 1'b0;
      result_ch    <= 3'd0;
      result_data  <= 12'd0;
    end else if (capture && tag_valid && done) begin
      result_valid <= 1'b1;
      result_ch    <= tag;
      result_data  <= 12'(sum >> avg_log2);
    end else if (result_ready) begin
      result_valid <= 1'b0;
    end
  end

  assign adc_en  = (state != IDLE);
  assign adc_ack = (state == ACK);
  assign busy    = (state != IDLE);

endmodule

// File: doc/adc_scan_avg.md
Name: adc_scan_avg

Overview:
- Downstream consumer of the ADC serial capture stage (ADC128S052 front end).
- Drives the capture stage's enable, channel address and acknowledge, and round-robins over a mask of enabled inputs IN0–IN7.
- Averages 2^avg_log2 conversions per channel and presents one averaged 12-bit result per channel on a valid/ready output.
- Compensates for the ADC's one-conversion address pipeline: the data returned in conversion k belongs to the address sent in conversion k-1.

Parameters:
avg_log2, 2, log2 of samples averaged per channel; legal 0..4.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
scan_en  in  1  level; 1 = scanning enabled
channel_mask  in  8  bit i = 1 includes input INi in the scan
adc_ready  in  1  capture stage has a conversion result
d_signal  in  12  conversion result from the capture stage
adc_en  out  1  enable to the capture stage
adc_ack  out  1  acknowledge to the capture stage
address  out  3  channel address to the capture stage
result_valid  out  1  averaged result available
result_ready  in  1  downstream accepts the result
result_ch  out  3  channel of the result
result_data  out  12  averaged value
busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0; state IDLE; accumulator, count, tag and tag_valid cleared.
- States:
  - IDLE: adc_en=0.
    - Go to WAIT when scan_en=1 and channel_mask!=0.
    - On entry to WAIT, address <= lowest set mask bit and tag_valid <= 0.
  - WAIT: adc_en=1; waits for adc_ready=1.
    - Capture condition: adc_ready=1 and not (result_valid=1 and result_ready=0).
    - While the output is stalled, no capture occurs, so the capture stage is backpressured and no data is lost.
  - ACK: adc_ack=1, held until adc_ready is sampled 0, then return to WAIT.
    - The capture stage samples ack on its slow clock, so ack must stay high across at least one slow-clock edge.
    - Exactly one sample is captured per adc_ready assertion.
- Capture actions, all in one clk cycle:
  - If tag_valid=1, the sample belongs to channel tag: acc += d_signal and cnt += 1.
  - If tag_valid=0, the sample is discarded. This happens for the first conversion after leaving IDLE, because its channel is unknown.
  - tag <= address; tag_valid <= 1.
  - address <= next scheduled channel.
- Scheduling:
  - Each channel's address is issued 2^avg_log2 consecutive times, counted by issue_cnt, then advances.
  - Next channel is the lowest set mask bit above the current one, wrapping from 7 to 0.
  - channel_mask is sampled only at the advance point; a mask change never alters the current channel's run.
  - If the new mask is 0 at the advance point, return to IDLE after the current ACK completes.
  - A single enabled channel repeats itself.
- Average completion: when cnt reaches 2^avg_log2 on a capture:
  - result_data <= (acc + d_signal) >> avg_log2, truncating; result_ch <= tag; result_valid <= 1.
  - acc and cnt are cleared in the same cycle.
  - Accumulator width is 12+avg_log2 and cannot overflow.
  - avg_log2=0 passes each sample straight through.
- Output handshake: result_valid stays 1 with data stable until a cycle with result_ready=1, then clears. There is no back-to-back overwrite.
- scan_en=0 in any non-IDLE state:
  - If in ACK, finish the ACK first (adc_ack must complete so the capture stage does not hang).
  - Then go to IDLE; adc_en=0.
  - acc, cnt and tag_valid are cleared; a partial average is dropped.
  - A pending result is kept until accepted.
- Async reset mid-operation: everything returns to reset values immediately, and adc_ack drops to 0.
- Simultaneous events:
  - result_ready=1 in the same cycle as a completing capture: the old result is accepted and the new one loaded, so result_valid stays 1.
  - A capture is permitted in that cycle because ready=1.

Test Plan:
- Basic scan: mask=8'h05, avg_log2=2, ADC model returns 12'h100+16*addr_prev (address from the previous conversion).
  - First sample is discarded.
  - Results must be ch0=12'h100, then ch2=12'h120, alternating.
  - address sequence 0,0,0,0,2,2,2,2,0...
- Averaging/truncation: single channel mask=8'h08, samples 1,2,2,2 -> result_data=1 (7>>2), result_ch=3.
- Backpressure: hold result_ready=0 after the first result.
  - No further adc_ack pulses until ready=1.
  - result_data stays stable.
  - Released results arrive in order with no loss.
- Ack handshake: adc_ready held high for 10 clk after ack -> adc_ack stays high the whole time and exactly one sample is counted.
- Mask change and empty mask:
  - Switch mask 8'h05->8'h80 mid ch0 run -> ch0 completes its 4 issues, next address=7.
  - Mask=0 at an advance point -> IDLE and adc_en=0.
- Abort/reset:
  - scan_en=0 during ACK -> ack completes, then IDLE; the partial average is not output.
  - rst pulse mid-WAIT -> all outputs 0 asynchronously.
